// File: rtl/uart_pkg.sv
// Shared types for the UART transmit framer: framer states, transmitter
// handshake phases and the default frame sync byte.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CSUM,
    DONE
  } framer_state_e;

  typedef enum logic [1:0] {
    IDLE_TX,
    SENT,
    BUSY
  } tx_phase_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte stream in and transmitter handshake out of the framer; the producer and
// transmitter side uses master, the framer uses slave.
interface uart_tx_framer_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       last_in;
  logic       ready_out;
  logic [7:0] tx_byte_out;
  logic       tx_trigger_out;
  logic       tx_busy_in;
  logic       frame_done_out;

  modport master (
    output data_in, valid_in, last_in, tx_busy_in,
    input  ready_out, tx_byte_out, tx_trigger_out, frame_done_out
  );

  modport slave (
    input  data_in, valid_in, last_in, tx_busy_in,
    output ready_out, tx_byte_out, tx_trigger_out, frame_done_out
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; pushes when full
// and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffers a delimited byte stream and hands each packet to the UART transmitter
// as SYNC, payload, XOR checksum, one registered trigger per byte.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  uart_tx_framer_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

  framer_state_e state_q, state_d;
  tx_phase_e     phase_q;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    csum_q, csum_d;
  logic          trig_q, done_q, done_d;
  logic          fire, pop, push, line_free;
  logic [8:0]    fifo_rd_data;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign bus.ready_out      = !rst_in && (fifo_count != FULL_CNT);
  assign push               = bus.valid_in && bus.ready_out && !fifo_full;
  assign bus.tx_byte_out    = byte_q;
  assign bus.tx_trigger_out = trig_q;
  assign bus.frame_done_out = done_q;

  // The line counts as free only once the previous trigger has seen busy rise and fall.
  assign line_free = (phase_q == IDLE_TX) && !bus.tx_busy_in;

  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (push),
    .wr_data ({bus.last_in, bus.data_in}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    csum_d  = csum_q;
    fire    = 1'b0;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && line_free) begin
          fire    = 1'b1;
          byte_d  = SYNC_BYTE;
          csum_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!fifo_empty && line_free) begin
          fire   = 1'b1;
          pop    = 1'b1;
          byte_d = fifo_rd_data[7:0];
          csum_d = csum_q ^ fifo_rd_data[7:0];
          if (fifo_rd_data[8]) state_d = CSUM;
        end
      end
      CSUM: begin
        if (line_free) begin
          fire    = 1'b1;
          byte_d  = csum_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (phase_q == IDLE_TX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      phase_q <= IDLE_TX;
      byte_q  <= '0;
      csum_q  <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
      trig_q  <= fire;
      done_q  <= done_d;
      if (fire) begin
        phase_q <= SENT;
      end else begin
        case (phase_q)
          SENT:    if (bus.tx_busy_in)  phase_q <= BUSY;
          BUSY:    if (!bus.tx_busy_in) phase_q <= IDLE_TX;
          default: phase_q <= IDLE_TX;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Drives packets into uart_tx_framer against a behavioural transmitter model and
// compares every triggered byte with frames built from SYNC, payload and XOR.
module tb_uart_tx_framer;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  uart_tx_framer_if bus();

  uart_tx_framer #(.FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int rise_delay = 1;
  int hold_len = 10;
  bit stall = 1'b0;
  int rise_cnt = 0;
  int hold_cnt = 0;
  int done_cnt = 0;
  int double_trig = 0;
  int done_busy = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];

  // Transmitter: busy rises rise_delay cycles after a trigger and stays high hold_len cycles.
  always @(posedge clk_in) begin
    #1;
    if ($isunknown(bus.tx_busy_in)) bus.tx_busy_in = 1'b0;
    if (stall) begin
      bus.tx_busy_in = 1'b1;
      rise_cnt = 0;
      hold_cnt = 0;
    end else begin
      if (bus.tx_busy_in && hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) bus.tx_busy_in = 1'b0;
      end else if (bus.tx_busy_in) begin
        bus.tx_busy_in = 1'b0;
      end
      if (rise_cnt > 0) begin
        rise_cnt--;
        if (rise_cnt == 0) begin
          bus.tx_busy_in = 1'b1;
          hold_cnt = hold_len;
        end
      end
    end
    if (bus.tx_trigger_out) begin
      if (rise_cnt > 0 || bus.tx_busy_in) double_trig++;
      got.push_back(bus.tx_byte_out);
      rise_cnt = rise_delay;
    end
    if (bus.frame_done_out) begin
      done_cnt++;
      if (bus.tx_busy_in) done_busy++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1);
  end

  function automatic void expect_frame();
    logic [7:0] cs = 8'h00;
    exp_q.push_back(8'hA5);
    foreach (pkt[i]) begin
      exp_q.push_back(pkt[i]);
      cs = cs ^ pkt[i];
    end
    exp_q.push_back(cs);
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    @(negedge clk_in);
    bus.data_in  = d;
    bus.last_in  = l;
    bus.valid_in = 1'b1;
    while (!bus.ready_out && guard < 2000) begin
      @(negedge clk_in);
      guard++;
    end
    if (!bus.ready_out) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL push_timeout ready_out=%b required 1", bus.ready_out);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) push_byte(pkt[i], (i == pkt.size() - 1));
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    expect_frame();
  endtask

  task automatic wait_frames(input int n, input string name);
    int guard = 0;
    while (done_cnt < n && guard < 4000) begin
      @(posedge clk_in);
      #2;
      guard++;
    end
    if (done_cnt < n) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout frames %0d required %0d", name, done_cnt, n);
    end
    repeat (20) @(posedge clk_in);
    #2;
  endtask

  task automatic start_test();
    int guard = 0;
    while ((bus.tx_busy_in || rise_cnt > 0) && guard < 200) begin
      @(posedge clk_in);
      #2;
      guard++;
    end
    repeat (3) @(posedge clk_in);
    #2;
    got = {};
    exp_q = {};
    pkt = {};
    done_cnt = 0;
    double_trig = 0;
    done_busy = 0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    tests_run++;
    if (bus.ready_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready got %b required 0", bus.ready_out); end
    tests_run++;
    if (bus.tx_trigger_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_trigger got %b required 0", bus.tx_trigger_out); end
    tests_run++;
    if (bus.tx_byte_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_byte got %h required 00", bus.tx_byte_out); end
    tests_run++;
    if (bus.frame_done_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b required 0", bus.frame_done_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    tests_run++;
    if (bus.ready_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready_after got %b required 1", bus.ready_out); end
  endtask

  task automatic test_basic();
    logic [7:0] g;
    start_test();
    pkt = '{8'h01, 8'h02, 8'h03};
    send_pkt();
    wait_frames(1, "basic");
    tests_run++;
    if (got.size() != exp_q.size()) begin tests_failed++; $display("[TB] FAIL basic_len got %0d required %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      tests_run++;
      if (g !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL basic_byte%0d got %h required %h", i, g, exp_q[i]); end
    end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL basic_done_count got %0d required 1", done_cnt); end
    tests_run++;
    if (done_busy != 0) begin tests_failed++; $display("[TB] FAIL basic_done_while_busy got %0d required 0", done_busy); end
  endtask

  task automatic test_single();
    logic [7:0] g;
    start_test();
    pkt = '{8'h5A};
    send_pkt();
    wait_frames(1, "single");
    tests_run++;
    if (got.size() != 3) begin tests_failed++; $display("[TB] FAIL single_len got %0d required 3", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      tests_run++;
      if (g !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL single_byte%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_slow_busy();
    logic [7:0] g;
    start_test();
    rise_delay = 3;
    for (int i = 0; i < 3; i++) pkt.push_back(8'($urandom));
    send_pkt();
    wait_frames(1, "slow_busy");
    rise_delay = 1;
    tests_run++;
    if (double_trig != 0) begin tests_failed++; $display("[TB] FAIL slow_busy_double_trigger got %0d required 0", double_trig); end
    tests_run++;
    if (got.size() != exp_q.size()) begin tests_failed++; $display("[TB] FAIL slow_busy_len got %0d required %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      tests_run++;
      if (g !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL slow_busy_byte%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g;
    int n;
    start_test();
    for (int p = 0; p < 4; p++) begin
      pkt = {};
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      send_pkt();
    end
    wait_frames(4, "back_to_back");
    tests_run++;
    if (done_cnt != 4) begin tests_failed++; $display("[TB] FAIL b2b_done_count got %0d required 4", done_cnt); end
    tests_run++;
    if (double_trig != 0) begin tests_failed++; $display("[TB] FAIL b2b_double_trigger got %0d required 0", double_trig); end
    tests_run++;
    if (got.size() != exp_q.size()) begin tests_failed++; $display("[TB] FAIL b2b_len got %0d required %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      tests_run++;
      if (g !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL b2b_byte%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_full();
    logic [7:0] g;
    int accepted = 0;
    int guard = 0;
    start_test();
    stall = 1'b1;
    repeat (3) @(posedge clk_in);
    for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      bus.data_in  = pkt[i];
      bus.last_in  = (i == 19);
      bus.valid_in = 1'b1;
      if (!bus.ready_out) break;
      @(posedge clk_in);
      #1;
      accepted++;
    end
    tests_run++;
    if (accepted != 16) begin tests_failed++; $display("[TB] FAIL full_accepted got %0d required 16", accepted); end
    tests_run++;
    if (bus.ready_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_ready got %b required 0", bus.ready_out); end
    stall = 1'b0;
    while (!bus.ready_out && guard < 300) begin
      @(negedge clk_in);
      guard++;
    end
    tests_run++;
    if (bus.ready_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_ready_return got %b required 1", bus.ready_out); end
    @(posedge clk_in);
    #1;
    for (int i = accepted + 1; i < 20; i++) push_byte(pkt[i], (i == 19));
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    expect_frame();
    wait_frames(1, "full");
    tests_run++;
    if (got.size() != exp_q.size()) begin tests_failed++; $display("[TB] FAIL full_len got %0d required %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      tests_run++;
      if (g !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL full_byte%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] g;
    start_test();
    push_byte(8'h11, 1'b0);
    bus.valid_in = 1'b0;
    repeat (50) @(posedge clk_in);
    #2;
    tests_run++;
    if (got.size() != 2) begin tests_failed++; $display("[TB] FAIL underrun_stall_len got %0d required 2", got.size()); end
    g = (got.size() > 1) ? got[1] : 8'hxx;
    tests_run++;
    if (g !== 8'h11) begin tests_failed++; $display("[TB] FAIL underrun_stall_byte got %h required 11", g); end
    tests_run++;
    if (done_cnt != 0) begin tests_failed++; $display("[TB] FAIL underrun_early_done got %0d required 0", done_cnt); end
    push_byte(8'h22, 1'b1);
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    pkt = '{8'h11, 8'h22};
    expect_frame();
    wait_frames(1, "underrun");
    tests_run++;
    if (got.size() != 4) begin tests_failed++; $display("[TB] FAIL underrun_len got %0d required 4", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      tests_run++;
      if (g !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL underrun_byte%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] g;
    int guard = 0;
    int n;
    start_test();
    for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom));
    send_pkt();
    while (got.size() < 3 && guard < 500) begin
      @(posedge clk_in);
      #2;
      guard++;
    end
    tests_run++;
    if (got.size() < 3) begin tests_failed++; $display("[TB] FAIL reset_mid_reach got %0d required 3", got.size()); end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    tests_run++;
    if (bus.ready_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mid_ready got %b required 0", bus.ready_out); end
    tests_run++;
    if (bus.tx_byte_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_mid_byte got %h required 00", bus.tx_byte_out); end
    tests_run++;
    if (bus.tx_trigger_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mid_trigger got %b required 0", bus.tx_trigger_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    n = got.size();
    repeat (40) @(posedge clk_in);
    #2;
    tests_run++;
    if (got.size() != n) begin tests_failed++; $display("[TB] FAIL reset_mid_quiet got %0d triggers required 0", got.size() - n); end
    tests_run++;
    if (done_cnt != 0) begin tests_failed++; $display("[TB] FAIL reset_mid_done got %0d required 0", done_cnt); end
    got = {};
    exp_q = {};
    pkt = '{8'h7E};
    send_pkt();
    wait_frames(1, "reset_mid");
    tests_run++;
    if (got.size() != 3) begin tests_failed++; $display("[TB] FAIL reset_mid_len got %0d required 3", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      tests_run++;
      if (g !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL reset_mid_byte%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  initial begin
    rst_in       = 1'b1;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    bus.data_in  = 8'h00;
    test_reset();
    test_basic();
    test_single();
    test_slow_busy();
    test_back_to_back();
    test_full();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
